// File: rtl/sa_pkg.sv
// Shared FSM state encoding and default geometry for the
// systolic-array sequencing controller.
package sa_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;
  localparam int KW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } sa_state_e;

endpackage

// File: rtl/sa_skew_line.sv
// One operand lane delay line; DEPTH=0 is a wire.
// Zeros entering the line propagate as bubbles.
module sa_skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk;
    assign unused_clk = clk ^ rst_n;
    assign dout = din;
  end else begin : g_sr
    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int d = 0; d < DEPTH; d++) sr[d] <= '0;
      end else begin
        sr[0] <= din;
        for (int d = 1; d < DEPTH; d++) sr[d] <= sr[d-1];
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequencer for an N x N output-stationary systolic array.
// Optional cycle counter port enabled by SA_SEQ_CTRL_PERF_EN.
module sa_seq_ctrl
  import sa_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int DATA_WIDTH = DW_DEF,
  parameter int ACC_WIDTH  = AW_DEF,
  parameter int K_WIDTH    = KW_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [K_WIDTH-1:0]        k_len,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [K_WIDTH-1:0]        rd_addr,
  input  logic [N*DATA_WIDTH-1:0]   a_rd_data,
  input  logic [N*DATA_WIDTH-1:0]   b_rd_data,
  output logic [N*DATA_WIDTH-1:0]   a_feed,
  output logic [N*DATA_WIDTH-1:0]   b_feed,
  output logic                      pe_enable,
  output logic                      acc_clr,
  input  logic [N*N*ACC_WIDTH-1:0]  psum_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N)-1:0]      out_row,
`ifdef SA_SEQ_CTRL_PERF_EN
  output logic [N*ACC_WIDTH-1:0]    out_data,
  output logic [31:0]               perf_cycles
`else
  output logic [N*ACC_WIDTH-1:0]    out_data
`endif
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N);
  localparam int DW = DATA_WIDTH;
  localparam int RL = N * ACC_WIDTH;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

  sa_state_e          state;
  logic [K_WIDTH-1:0] k_q;
  logic [FW-1:0]      fcnt;
  logic               rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_q       <= '0;
      fcnt      <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      pe_enable <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
    end else begin
      rd_valid <= rd_en;
      acc_clr  <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            k_q     <= k_len;
            busy    <= 1'b1;
            acc_clr <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          if (k_q == '0) begin
            out_valid <= 1'b1;
            out_row   <= '0;
            state     <= DRAIN;
          end else begin
            rd_en   <= 1'b1;
            rd_addr <= '0;
            state   <= FEED;
          end
        end
        FEED: begin
          // first datum lands on lane 0 the cycle after address 0
          if (rd_addr == '0) pe_enable <= 1'b1;
          if (rd_addr == k_q - 1'b1) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            fcnt    <= '0;
            state   <= FLUSH;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end
        FLUSH: begin
          if (fcnt == FLUSH_LAST) begin
            pe_enable <= 1'b0;
            out_valid <= 1'b1;
            out_row   <= '0;
            state     <= DRAIN;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (out_row == RW'(N-1)) begin
              out_valid <= 1'b0;
              out_row   <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              out_row <= out_row + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // psums are final after the last enable edge, so mux them live
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int r = 0; r < N; r++) begin
        if (out_row == RW'(r)) out_data = psum_in[r*RL +: RL];
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;

    assign a_in = rd_valid ? a_rd_data[i*DW +: DW] : '0;
    assign b_in = rd_valid ? b_rd_data[i*DW +: DW] : '0;

    sa_skew_line #(.DEPTH(i), .W(DW)) u_a (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (a_in),
      .dout (a_feed[i*DW +: DW])
    );

    sa_skew_line #(.DEPTH(i), .W(DW)) u_b (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (b_in),
      .dout (b_feed[i*DW +: DW])
    );
  end

`ifdef SA_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
    end else if (state == IDLE && start) begin
      perf_cycles <= 32'd1;
    end else if (busy && perf_cycles != '1) begin
      perf_cycles <= perf_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Bench for sa_seq_ctrl: buffer + PE array models, matmul reference.
// Checks perf_cycles when SA_SEQ_CTRL_PERF_EN is defined.
module tb_sa_seq_ctrl;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int KW = 8;
  localparam int RW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              busy, done, rd_en, pe_enable, acc_clr;
  logic [KW-1:0]     rd_addr;
  logic [N*DW-1:0]   a_rd_data = '0;
  logic [N*DW-1:0]   b_rd_data = '0;
  logic [N*DW-1:0]   a_feed, b_feed;
  logic [N*N*AW-1:0] psum_in;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [RW-1:0]     out_row;
  logic [N*AW-1:0]   out_data;
`ifdef SA_SEQ_CTRL_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  sa_seq_ctrl #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
`ifdef SA_SEQ_CTRL_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .a_feed(a_feed), .b_feed(b_feed),
    .pe_enable(pe_enable), .acc_clr(acc_clr), .psum_in(psum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // operand buffers: A column k, B row k; one-cycle read latency
  int a_mem [256][N];
  int b_mem [256][N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rd_en) begin
        a_rd_data[i*DW +: DW] <= DW'(a_mem[rd_addr][i]);
        b_rd_data[i*DW +: DW] <= DW'(b_mem[rd_addr][i]);
      end else begin
        a_rd_data[i*DW +: DW] <= DW'($urandom);
        b_rd_data[i*DW +: DW] <= DW'($urandom);
      end
    end
  end

  // behavioural output-stationary array: a flows east, b flows south
  int acc [N][N];
  int ar  [N][N];
  int br  [N][N];

  function automatic int a_at(int i, int j);
    logic signed [DW-1:0] v;
    if (j == 0) begin
      v = a_feed[i*DW +: DW];
      return int'(v);
    end
    return ar[i][j-1];
  endfunction

  function automatic int b_at(int i, int j);
    logic signed [DW-1:0] v;
    if (i == 0) begin
      v = b_feed[j*DW +: DW];
      return int'(v);
    end
    return br[i-1][j];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!rst_n || acc_clr) begin
          acc[i][j] <= 0;
          ar[i][j]  <= 0;
          br[i][j]  <= 0;
        end else if (pe_enable) begin
          acc[i][j] <= acc[i][j] + a_at(i, j) * b_at(i, j);
          ar[i][j]  <= a_at(i, j);
          br[i][j]  <= b_at(i, j);
        end
      end
    end
  end

  always_comb begin
    psum_in = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        psum_in[(r*N+c)*AW +: AW] = acc[r][c];
  end

  function automatic int exp_c(int k, int i, int j);
    int s = 0;
    for (int kk = 0; kk < k; kk++) s += a_mem[kk][i] * b_mem[kk][j];
    return s;
  endfunction

  function automatic int lane32(logic [N*AW-1:0] d, int j);
    return int'(d[j*AW +: AW]);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic fill_rand(input int k);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < N; i++) begin
        a_mem[kk][i] = int'($urandom_range(0, 200)) - 100;
        b_mem[kk][i] = int'($urandom_range(0, 200)) - 100;
      end
  endtask

  task automatic fill_ident();
    for (int kk = 0; kk < N; kk++)
      for (int i = 0; i < N; i++) begin
        a_mem[kk][i] = (kk == i) ? 1 : 0;
        b_mem[kk][i] = kk * N + i + 1;
      end
  endtask

  int s_cyc, clr_cyc, clr_n, rd_first, rd_cnt, addr_bad;
  int pe_first, pe_last, pe_cnt, pe_gap;
  int dv_first, dv_cnt, xfer_cnt, row_bad, stall_bad;
  int done_cyc, busy_bad;

  task automatic run_op(input int k, input int stall_row,
                        input int stall_len, input bit poke);
    int stalled = 0;
    logic [RW-1:0]   h_row = '0;
    logic [N*AW-1:0] h_data = '0;
    clr_cyc = -1; clr_n = 0; rd_first = -1; rd_cnt = 0; addr_bad = 0;
    pe_first = -1; pe_last = -1; pe_cnt = 0; pe_gap = 0;
    dv_first = -1; dv_cnt = 0; xfer_cnt = 0; row_bad = 0;
    stall_bad = 0; done_cyc = -1; busy_bad = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    s_cyc = cyc;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      start = poke && (t == 3 || (out_valid && dv_cnt == 1));
      if (start) k_len = KW'(k + 5);
      if (!busy) busy_bad++;
      if (acc_clr) begin
        if (clr_cyc < 0) clr_cyc = cyc;
        clr_n++;
      end
      if (rd_en) begin
        if (rd_addr != KW'(rd_cnt)) addr_bad++;
        if (rd_first < 0) rd_first = cyc;
        rd_cnt++;
      end
      if (pe_enable) begin
        if (pe_first < 0) pe_first = cyc;
        else if (pe_last != cyc - 1) pe_gap++;
        pe_last = cyc;
        pe_cnt++;
      end
      if (out_valid) begin
        if (dv_first < 0) dv_first = cyc;
        dv_cnt++;
        if (stall_row >= 0 && out_row == RW'(stall_row) &&
            stalled < stall_len) begin
          if (stalled == 0) begin
            h_row = out_row;
            h_data = out_data;
          end else if (out_row !== h_row || out_data !== h_data) begin
            stall_bad++;
          end
          stalled++;
          out_ready = 1'b0;
        end else begin
          if (stalled > 0 && out_row == RW'(stall_row) &&
              out_data !== h_data) stall_bad++;
          out_ready = 1'b1;
          if (out_row != RW'(xfer_cnt)) row_bad++;
          for (int j = 0; j < N; j++)
            chk($sformatf("k%0d_row%0d_col%0d", k, xfer_cnt, j),
                lane32(out_data, j), exp_c(k, xfer_cnt, j));
          xfer_cnt++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_run(input int k, input int stall_len);
    int exp_pe;
    exp_pe = (k == 0) ? 0 : k + 2*N - 2;
    chk("clr_cycle", clr_cyc - s_cyc, 1);
    chk("clr_once", clr_n, 1);
    chk("rd_cnt", rd_cnt, k);
    chk("rd_addr_seq", addr_bad, 0);
    chk("pe_cnt", pe_cnt, exp_pe);
    chk("pe_contig", pe_gap, 0);
    if (k > 0) begin
      chk("rd_first", rd_first - s_cyc, 2);
      chk("pe_first", pe_first - s_cyc, 3);
      chk("drain_after_pe", dv_first - pe_last, 1);
    end else begin
      chk("drain_first", dv_first - s_cyc, 2);
    end
    chk("drain_cycles", dv_cnt, N + stall_len);
    chk("rows_xfer", xfer_cnt, N);
    chk("row_order", row_bad, 0);
    chk("stall_hold", stall_bad, 0);
    chk("done_after_drain", done_cyc - (dv_first + dv_cnt), 0);
    chk("busy_span", busy_bad, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
`ifdef SA_SEQ_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles, done_cyc - s_cyc + 1);
`endif
  endtask

  int done_seen;

  initial begin
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", |{busy, done, rd_en, rd_addr, a_feed, b_feed,
                        pe_enable, acc_clr, out_valid, out_row,
                        out_data}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);

    fill_rand(3);
    run_op(3, -1, 0, 1'b0);
    check_run(3, 0);

    fill_ident();
    run_op(4, -1, 0, 1'b0);
    check_run(4, 0);

    run_op(0, -1, 0, 1'b0);
    check_run(0, 0);

    fill_rand(5);
    run_op(5, 2, 5, 1'b0);
    check_run(5, 5);

    fill_rand(6);
    @(negedge clk);
    start = 1'b1;
    k_len = 8'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_feed", rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", |{busy, done, rd_en, rd_addr, a_feed, b_feed,
                        pe_enable, acc_clr, out_valid, out_row,
                        out_data}, 0);
    done_seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (t == 2) rst_n = 1'b1;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_idle", busy, 0);
    fill_rand(2);
    run_op(2, -1, 0, 1'b0);
    check_run(2, 0);

    fill_rand(3);
    run_op(3, -1, 0, 1'b1);
    check_run(3, 0);

    for (int r = 0; r < 4; r++) begin
      int k;
      k = int'($urandom_range(1, 12));
      fill_rand(k);
      run_op(k, int'($urandom_range(0, N-1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
      check_run(k, dv_cnt - N);
      chk("rand_stall_bound", (dv_cnt - N) <= 3, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa_seq_ctrl.md
SA_SEQ_CTRL -- requirements
Module: sa_seq_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N PEs).
REQ-002 Parameter DATA_WIDTH, default 16: signed operand width.
REQ-003 Parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-004 Parameter K_WIDTH, default 8: width of the reduction-length field.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  one-cycle request to run one N x N x k_len matrix product.
REQ-008 k_len  input  K_WIDTH  reduction length, sampled when start is accepted.
REQ-009 busy  output  1  high from start acceptance until the done cycle, inclusive.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rd_en  output  1  read strobe to the A and B operand buffers.
REQ-012 rd_addr  output  K_WIDTH  reduction index k; buffer data is returned one cycle later.
REQ-013 a_rd_data / b_rd_data  input  N*DATA_WIDTH  A column k (lane i = row i) / B row k (lane j = column j).
REQ-014 a_feed / b_feed  output  N*DATA_WIDTH  skewed operands to the array's west / north edges.
REQ-015 pe_enable  output  1  accumulate enable broadcast to all PEs.
REQ-016 acc_clr  output  1  one-cycle synchronous accumulator clear to the array wrapper.
REQ-017 psum_in  input  N*N*ACC_WIDTH  array partial sums; row r occupies bits [r*N*ACC_WIDTH +: N*ACC_WIDTH].
REQ-018 out_valid / out_ready  output / input  1  drain handshake.
REQ-019 out_row  output  $clog2(N)  index of the row being drained.
REQ-020 out_data  output  N*ACC_WIDTH  psum row out_row.

Function
REQ-021 FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
REQ-022 IDLE with start=1: latch k_len, assert busy, and go to CLEAR; start in any other state is ignored.
REQ-023 CLEAR: acc_clr=1 for exactly one cycle; next state is FEED, or DRAIN if the latched k_len==0.
REQ-024 FEED: rd_en=1 for k_len consecutive cycles with rd_addr=0,1,...,k_len-1; then go to FLUSH.
REQ-025 Lane i of a_feed and lane j of b_feed are delayed by i and j extra cycles beyond the read latency.
REQ-026 Each skew stage injects zero whenever no valid read datum is entering that stage.
REQ-027 pe_enable is high for exactly k_len+2N-2 consecutive cycles, starting the cycle the first read datum reaches lane 0.
REQ-028 FLUSH ends on the last pe_enable cycle; the next state is DRAIN.
REQ-029 DRAIN: out_valid=1 with out_row=0..N-1 in order; out_row advances on out_valid&&out_ready.
REQ-030 While out_ready=0, out_row and out_data are held stable.
REQ-031 The transfer of row N-1 moves the FSM to DONE.
REQ-032 DONE: done=1 for one cycle; next state is IDLE, where busy=0.
REQ-033 No arithmetic is performed; psum is passed through unmodified and sign is not interpreted.

Reset
REQ-034 While rst_n=0, all outputs are 0, the FSM is in IDLE, and the skew registers and counters are cleared.
REQ-035 Reset asserted mid-operation aborts the run with no done pulse; after release the block waits for a new start.

Configuration
REQ-036 With SA_SEQ_CTRL_PERF_EN defined, the output perf_cycles[31:0] counts the cycles from start acceptance to done, inclusive.
REQ-037 perf_cycles saturates at all-ones and holds its value until the next start is accepted.
REQ-038 Without SA_SEQ_CTRL_PERF_EN, the perf_cycles port and its counter do not exist.

Structure
REQ-039 Package sa_pkg holds the FSM state enum and default N / DATA_WIDTH / ACC_WIDTH / K_WIDTH localparams.
REQ-040 Sub-module sa_skew_line (parameter DEPTH) implements one lane delay line and is instantiated 2N times.

Verification
REQ-041 N=4, k_len=3, out_ready=1:
- acc_clr occurs 1 cycle after start; rd_en is high for 3 cycles.
- pe_enable is high for 9 cycles; DRAIN lasts 4 cycles; done follows.
REQ-042 Stimulus: A = identity, B rows = [1,2,3,4], [5,6,7,8], [9,10,11,12], k_len=4, with a behavioural PE array.
- Response: drained rows equal B.
REQ-043 k_len=0: CLEAR is followed directly by 4 drain rows of zeros, with no rd_en and no pe_enable.
REQ-044 out_ready=0 for 5 cycles on row 2: out_row stays 2 and out_data is stable; all 4 rows arrive exactly once.
REQ-045 Reset pulse during FEED: all outputs go to 0 with no done pulse; a new start then completes normally.
REQ-046 start pulses while busy are ignored. With PERF_EN, k_len=3, N=4: perf_cycles equals the measured start-to-done span.
